// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport integer register file.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

    localparam int unsigned RF_XLEN_DEFAULT = 32;

    // Address width for a register file of n entries.
    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Post-reset clear engine: sweeps entries 1..NREGS-1 writing zero, one per cycle,
// so the storage array itself needs no reset and can map to block RAM.
module rf_clear_fsm
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          busy_q, busy_d;

    // Next-state: advance the sweep index, leave CLEAR after the last entry is written.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        if (state_q == RF_CLEAR) begin
            if (clr_idx_q == LastIdx) begin
                state_d = RF_RUN;
                busy_d  = 1'b0;
            end else begin
                clr_idx_d = clr_idx_q + AW'(1);
            end
        end
    end

    // State registers; reset restarts the sweep from entry 1 regardless of current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Clear writes only happen on cycles where reset is released.
    always_comb begin
        busy     = busy_q;
        clr_we   = (state_q == RF_CLEAR) && !reset;
        clr_addr = clr_idx_q;
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised RV32 integer register file: NREAD combinational read ports with optional
// write bypass, one write port, x0 hardwired to zero, and a registered debug read port.
module regfile_multiport
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN_DEFAULT,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW = rf_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic                  busy,
    input  logic                  dbg_req,
    input  logic [AW-1:0]         dbg_addr,
    output logic                  dbg_valid,
    output logic [XLEN-1:0]       dbg_data
);

    // Entry 0 is never written; reads of address 0 are forced to zero instead.
    logic [XLEN-1:0] mem_q [NREGS];

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic            dbg_valid_q, dbg_valid_d;
    logic [XLEN-1:0] dbg_data_q, dbg_data_d;

    rf_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Single memory write port: the clear engine owns it while busy, user writes otherwise.
    always_comb begin
        if (busy) begin
            mem_we    = clr_we;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_en && (wr_addr != '0);
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Storage array write; no reset so it can be inferred as RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports, each decoded independently.
    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[p*AW +: AW];

        // Zero for x0 or during the sweep, else optional same-cycle forward, else stored value.
        always_comb begin
            if (addr == '0 || busy) begin
                rd_data[p*XLEN +: XLEN] = '0;
            end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
            end else begin
                rd_data[p*XLEN +: XLEN] = mem_q[addr];
            end
        end
    end

    // Debug next-state: read-first capture of the pre-write value; requests while busy dropped.
    always_comb begin
        dbg_valid_d = dbg_req && !busy;
        dbg_data_d  = dbg_data_q;
        if (dbg_valid_d) begin
            dbg_data_d = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
        end
    end

    // Debug output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: default 32x32 2-read bypassing file plus a 16-entry, 3-read, no-bypass file.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_valid;
    logic [31:0] dbg_data;

    logic [11:0] rd_addr_b;
    logic [95:0] rd_data_b;
    logic        busy_b;
    logic        dbg_valid_b;
    logic [31:0] dbg_data_b;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    regfile_multiport u_dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_valid (dbg_valid),
        .dbg_data  (dbg_data)
    );

    regfile_multiport #(
        .XLEN   (32),
        .NREGS  (16),
        .NREAD  (3),
        .BYPASS (0)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr_b),
        .rd_data   (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr[3:0]),
        .wr_data   (wr_data),
        .busy      (busy_b),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr[3:0]),
        .dbg_valid (dbg_valid_b),
        .dbg_data  (dbg_data_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until each instance drops busy; stops at a bound.
    task automatic wait_clear(output int ca, output int cb);
        int cnt;
        cnt = 0;
        ca  = 0;
        cb  = 0;
        while ((busy !== 1'b0 || busy_b !== 1'b0) && cnt < 200) begin
            tick();
            cnt++;
            if (busy === 1'b0 && ca == 0) ca = cnt;
            if (busy_b === 1'b0 && cb == 0) cb = cnt;
        end
        if (ca == 0) ca = cnt;
        if (cb == 0) cb = cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, cb, pulses;
        logic saw_valid;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd4,  32'hA5A5A5A5, 32'h0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd3,  32'hFFFFFFFF, 32'hA5A5A5A5};
        tbl[7] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd31, 32'h12345678, 32'hFFFFFFFF};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  32'h12345678, 32'h0};
        tbl[9] = '{1'b1, 5'd9,  32'h11,       5'd9,  5'd9,  32'h11,       32'h11};

        reset     = 1'b1;
        rd_addr   = '0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;

        // Reset state, then a write attempt to x7 held through the whole sweep.
        tick();
        reset = 1'b0;
        check("reset_busy", busy, 1'b1);
        check("reset_dbg_valid", dbg_valid, 1'b0);
        check("reset_dbg_data", dbg_data, 32'h0);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h777;
        rd_addr = {5'd7, 5'd7};
        #1;
        check("busy_read_zero", rd_data, 64'h0);
        wait_clear(ca, cb);
        wr_en = 1'b0;
        check("sweep_cycles_32", ca, 31);
        check("sweep_cycles_16", cb, 15);

        // Debug dump: every entry must read zero, including x7.
        for (int i = 1; i < 32; i++) begin
            dbg_req  = 1'b1;
            dbg_addr = 5'(i);
            tick();
            check($sformatf("dump_x%0d", i), {dbg_valid, dbg_data}, {1'b1, 32'h0});
        end
        dbg_req = 1'b0;

        // Table-driven write/read vectors on the bypassing instance.
        for (int i = 0; i < 10; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            check($sformatf("vec%0d_p0", i), rd_data[31:0], tbl[i].e0);
            check($sformatf("vec%0d_p1", i), rd_data[63:32], tbl[i].e1);
            tick();
        end
        wr_en = 1'b0;

        // Debug read of x0 after the dropped x0 write.
        dbg_req  = 1'b1;
        dbg_addr = 5'd0;
        tick();
        dbg_req = 1'b0;
        check("dbg_x0", {dbg_valid, dbg_data}, {1'b1, 32'h0});

        // Read-first debug: same-edge write of x9 is not visible.
        dbg_req  = 1'b1;
        dbg_addr = 5'd9;
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h55;
        tick();
        dbg_req = 1'b0;
        wr_en   = 1'b0;
        check("dbg_read_first", {dbg_valid, dbg_data}, {1'b1, 32'h11});
        tick();
        check("dbg_hold", {dbg_valid, dbg_data}, {1'b0, 32'h11});
        rd_addr = {5'd0, 5'd9};
        #1;
        check("x9_after_write", rd_data[31:0], 32'h55);

        // Held request: one read per cycle.
        pulses  = 0;
        dbg_req = 1'b1;
        dbg_addr = 5'd3;
        tick();
        if (dbg_valid === 1'b1) pulses++;
        check("held_x3", dbg_data, 32'hA5A5A5A5);
        dbg_addr = 5'd5;
        tick();
        if (dbg_valid === 1'b1) pulses++;
        check("held_x5", dbg_data, 32'h12345678);
        dbg_addr = 5'd31;
        tick();
        if (dbg_valid === 1'b1) pulses++;
        check("held_x31", dbg_data, 32'hFFFFFFFF);
        dbg_addr = 5'd9;
        tick();
        if (dbg_valid === 1'b1) pulses++;
        check("held_x9", dbg_data, 32'h55);
        dbg_req = 1'b0;
        tick();
        if (dbg_valid === 1'b1) pulses++;
        check("held_pulses", pulses, 4);

        // No-bypass instance: same-cycle read sees old value on all three ports.
        wr_en     = 1'b1;
        wr_addr   = 5'd6;
        wr_data   = 32'hCAFEF00D;
        rd_addr   = {5'd6, 5'd6};
        rd_addr_b = {4'd6, 4'd6, 4'd6};
        #1;
        check("nobyp_same_cycle", rd_data_b, 96'h0);
        check("byp_same_cycle", rd_data, {2{32'hCAFEF00D}});
        tick();
        wr_en = 1'b0;
        #1;
        check("nobyp_next_cycle", rd_data_b, {3{32'hCAFEF00D}});

        // Reset from RUN, then again at sweep cycle 10: full restart, x20 cleared.
        wr_en   = 1'b1;
        wr_addr = 5'd20;
        wr_data = 32'h77;
        tick();
        wr_en   = 1'b0;
        rd_addr = {5'd20, 5'd20};
        #1;
        check("x20_written", rd_data[31:0], 32'h77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_dbg_data", {dbg_valid, dbg_data}, {1'b0, 32'h0});
        for (int i = 0; i < 10; i++) tick();
        check("mid_sweep_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        dbg_req   = 1'b1;
        dbg_addr  = 5'd5;
        saw_valid = 1'b0;
        ca        = 0;
        while (busy !== 1'b0 && ca < 200) begin
            tick();
            ca++;
            if (dbg_valid !== 1'b0) saw_valid = 1'b1;
        end
        dbg_req = 1'b0;
        check("restart_sweep_cycles", ca, 31);
        check("dbg_req_while_busy", saw_valid, 1'b0);
        #1;
        check("x20_cleared", rd_data, 64'h0);
        tick();
        check("no_queued_dbg", dbg_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
